// File: rtl/systolic_mac_pe.sv
// Systolic-array PE: stationary-weight signed multiply-accumulate, saturating or wrapping to ACC_W bits.
// Latency: value/valid east after 1 accepted edge; partial sum south after 2 accepted edges.
// Backpressure: en==0 freezes every pipeline register and the weight; clear_ovf still acts while stalled.
//
// Ports:
//   clk, n_rst            clock and synchronous active-low reset (clears every register, weight included)
//   en                    pipeline advance; low holds all state
//   load_weight/weight_in load the stationary weight (takes effect for the next accepted input)
//   value_in/psum_in      west operand and north partial sum, qualified by valid_in
//   clear_ovf             clears overflow_sticky
//   value_out/value_valid_out    west operand forwarded east, one stage later
//   psum_out/psum_valid_out      accumulated result to the south neighbour
//   overflow/overflow_sticky     per-result range violation and its latched summary
module systolic_mac_pe #(
    parameter int DATA_W   = 8,
    parameter int ACC_W    = 16,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     en,
    input  logic                     load_weight,
    input  logic signed [DATA_W-1:0] weight_in,
    input  logic signed [DATA_W-1:0] value_in,
    input  logic signed [ACC_W-1:0]  psum_in,
    input  logic                     valid_in,
    input  logic                     clear_ovf,
    output logic signed [DATA_W-1:0] value_out,
    output logic                     value_valid_out,
    output logic signed [ACC_W-1:0]  psum_out,
    output logic                     psum_valid_out,
    output logic                     overflow,
    output logic                     overflow_sticky
);

    localparam int PROD_W = 2 * DATA_W;
    // One guard bit above ACC_W is enough: the product fits in ACC_W bits
    // (ACC_W >= 2*DATA_W), so the sum of two ACC_W-bit values fits in ACC_W+1.
    localparam int SUM_W  = ACC_W + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [DATA_W-1:0] w_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  psum_q;
    logic                     v1_q;

    logic signed [PROD_W-1:0] mult;
    logic signed [SUM_W-1:0]  sum;
    logic                     out_of_range;
    logic signed [ACC_W-1:0]  result;
    logic                     ovf_set;

    // Both operands are widened to the product width so the multiply is
    // evaluated at full precision with sign extension.
    assign mult = $signed({{DATA_W{w_q[DATA_W-1]}}, w_q})
                * $signed({{DATA_W{value_in[DATA_W-1]}}, value_in});

    assign sum = $signed({{(SUM_W-PROD_W){prod_q[PROD_W-1]}}, prod_q})
               + $signed({psum_q[ACC_W-1], psum_q});

    // The ACC_W+1-bit sum is out of the ACC_W range exactly when its top two bits disagree.
    assign out_of_range = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        result = sum[ACC_W-1:0];
        if (out_of_range && (SATURATE != 0)) begin
            result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // overflow is only written on accepted edges, so the sticky bit can only be set then too.
    assign ovf_set = en && v1_q && out_of_range;

    // Stationary weight: the multiply on the load edge still uses the old value.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            w_q <= '0;
        end else if (en && load_weight) begin
            w_q <= weight_in;
        end
    end

    // Stage 1: product, partial-sum capture, and east forwarding.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            prod_q          <= '0;
            psum_q          <= '0;
            v1_q            <= 1'b0;
            value_out       <= '0;
            value_valid_out <= 1'b0;
        end else if (en) begin
            prod_q          <= mult;
            psum_q          <= psum_in;
            v1_q            <= valid_in;
            value_out       <= value_in;
            value_valid_out <= valid_in;
        end
    end

    // Stage 2: accumulate and range-limit. Invalid slots still compute but never flag overflow.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
            overflow       <= 1'b0;
        end else if (en) begin
            psum_out       <= result;
            psum_valid_out <= v1_q;
            overflow       <= v1_q && out_of_range;
        end
    end

    // Set has priority over clear so an overflow landing on a clear edge is not lost.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            overflow_sticky <= 1'b0;
        end else if (ovf_set) begin
            overflow_sticky <= 1'b1;
        end else if (clear_ovf) begin
            overflow_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: saturating and wrapping instances share stimulus.
// Expected values come from an arithmetic reference model (queue of accepted results).
// Directed scenarios first, then randomized traffic with stalls, loads, clears and resets.
module tb_systolic_mac_pe;

    localparam int DW = 8;
    localparam int AW = 16;

    logic                 clk;
    logic                 n_rst;
    logic                 en;
    logic                 load_weight;
    logic signed [DW-1:0] weight_in;
    logic signed [DW-1:0] value_in;
    logic signed [AW-1:0] psum_in;
    logic                 valid_in;
    logic                 clear_ovf;

    logic signed [DW-1:0] s_value_out, w_value_out;
    logic                 s_value_vld, w_value_vld;
    logic signed [AW-1:0] s_psum_out, w_psum_out;
    logic                 s_psum_vld, w_psum_vld;
    logic                 s_ovf, w_ovf;
    logic                 s_sticky, w_sticky;

    systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SATURATE(1)) dut_sat (
        .clk(clk), .n_rst(n_rst), .en(en), .load_weight(load_weight),
        .weight_in(weight_in), .value_in(value_in), .psum_in(psum_in),
        .valid_in(valid_in), .clear_ovf(clear_ovf),
        .value_out(s_value_out), .value_valid_out(s_value_vld),
        .psum_out(s_psum_out), .psum_valid_out(s_psum_vld),
        .overflow(s_ovf), .overflow_sticky(s_sticky)
    );

    systolic_mac_pe #(.DATA_W(DW), .ACC_W(AW), .SATURATE(0)) dut_wrap (
        .clk(clk), .n_rst(n_rst), .en(en), .load_weight(load_weight),
        .weight_in(weight_in), .value_in(value_in), .psum_in(psum_in),
        .valid_in(valid_in), .clear_ovf(clear_ovf),
        .value_out(w_value_out), .value_valid_out(w_value_vld),
        .psum_out(w_psum_out), .psum_valid_out(w_psum_vld),
        .overflow(w_ovf), .overflow_sticky(w_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit vld;
        int res_sat;
        int res_wrap;
        bit ovf;
    } rec_t;

    rec_t pipe[$];      // results of accepted inputs; pipe[0] is what psum_out shows
    rec_t zero_rec;
    int   m_w;
    int   m_val;
    bit   m_vv;
    bit   m_sticky;

    int   checks   = 0;
    int   failures = 0;
    int   got[$];       // valid psum_out values seen on accepted edges (saturating instance)

    function automatic int wrap16(int s);
        logic [AW-1:0] t;
        t = s[AW-1:0];
        return int'($signed(t));
    endfunction

    function automatic rec_t make_rec(int w, int v, int p, bit vld);
        rec_t r;
        int   s;
        bit   oor;
        s          = w * v + p;
        oor        = (s > 32767) || (s < -32768);
        r.vld      = vld;
        r.res_sat  = oor ? ((s > 0) ? 32767 : -32768) : s;
        r.res_wrap = wrap16(s);
        r.ovf      = vld && oor;
        return r;
    endfunction

    task automatic chk(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("sat_psum",      s_psum_out,  pipe[0].res_sat);
        chk("wrap_psum",     w_psum_out,  pipe[0].res_wrap);
        chk("sat_psum_vld",  s_psum_vld,  pipe[0].vld);
        chk("wrap_psum_vld", w_psum_vld,  pipe[0].vld);
        chk("sat_ovf",       s_ovf,       pipe[0].ovf);
        chk("wrap_ovf",      w_ovf,       pipe[0].ovf);
        chk("sat_sticky",    s_sticky,    m_sticky);
        chk("wrap_sticky",   w_sticky,    m_sticky);
        chk("sat_value",     s_value_out, m_val);
        chk("wrap_value",    w_value_out, m_val);
        chk("sat_value_vld", s_value_vld, m_vv);
        chk("wrap_value_vld",w_value_vld, m_vv);
    endtask

    // One clock edge: advance the model with the inputs the DUT sees, then compare.
    task automatic tick();
        rec_t r;
        bit   acc;
        @(posedge clk);
        acc = n_rst && en;
        if (!n_rst) begin
            pipe.delete();
            pipe.push_back(zero_rec);
            m_w      = 0;
            m_val    = 0;
            m_vv     = 0;
            m_sticky = 0;
        end else begin
            if (en) begin
                r = make_rec(m_w, int'(value_in), int'(psum_in), valid_in);
                pipe.push_back(r);
                if (pipe.size() > 2) void'(pipe.pop_front());
                m_val = int'(value_in);
                m_vv  = valid_in;
                if (load_weight) m_w = int'(weight_in);
            end
            if (en && pipe[0].ovf) m_sticky = 1;
            else if (clear_ovf)    m_sticky = 0;
        end
        #1;
        check_all();
        if (acc && s_psum_vld) got.push_back(int'(s_psum_out));
    endtask

    task automatic set_in(bit v, int val, int ps, bit ld = 0, int w = 0, bit e = 1, bit clr = 0);
        valid_in    = v;
        value_in    = val[DW-1:0];
        psum_in     = ps[AW-1:0];
        load_weight = ld;
        weight_in   = w[DW-1:0];
        en          = e;
        clear_ovf   = clr;
    endtask

    task automatic load_w(int w);
        set_in(0, 0, 0, 1, w);
        tick();
    endtask

    initial begin
        zero_rec = '{vld: 0, res_sat: 0, res_wrap: 0, ovf: 0};
        pipe.push_back(zero_rec);
        n_rst = 1'b0;
        set_in(0, 0, 0);

        // 1. reset held for two edges: all outputs zero, weight zero
        tick();
        tick();
        chk("rst_psum",   s_psum_out, 0);
        chk("rst_sticky", s_sticky,   0);
        n_rst = 1'b1;
        set_in(1, 50, 7);
        tick();
        set_in(0, 0, 0);
        tick();
        chk("rst_weight_zero", s_psum_out, 7);

        // 2. w=-3, value=5, psum=100
        load_w(-3);
        set_in(1, 5, 100);
        tick();
        chk("t2_value_out", s_value_out, 5);
        set_in(0, 0, 0);
        tick();
        chk("t2_psum",     s_psum_out, 85);
        chk("t2_psum_vld", s_psum_vld, 1);
        chk("t2_ovf",      s_ovf,      0);

        // 3. positive overflow: saturate vs wrap
        load_w(127);
        set_in(1, 127, 32767);
        tick();
        set_in(0, 0, 0);
        tick();
        chk("t3_sat_psum",  s_psum_out, 32767);
        chk("t3_wrap_psum", w_psum_out, -16640);
        chk("t3_sat_ovf",   s_ovf,      1);
        chk("t3_wrap_ovf",  w_ovf,      1);
        chk("t3_sticky",    s_sticky,   1);

        // 4. negative overflow then clear
        load_w(-128);
        set_in(1, 127, -32768);
        tick();
        set_in(0, 0, 0);
        tick();
        chk("t4_sat_psum", s_psum_out, -32768);
        chk("t4_ovf",      s_ovf,      1);
        set_in(0, 0, 0, 0, 0, 1, 1);
        tick();
        chk("t4_sticky_clr", s_sticky, 0);

        // 5. stream 1..4 with a three-cycle stall after the second input
        load_w(2);
        got.delete();
        set_in(1, 1, 0); tick();
        set_in(1, 2, 0); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 99, 1000, 1, 50, 0);
            tick();
        end
        set_in(1, 3, 0); tick();
        set_in(1, 4, 0); tick();
        set_in(0, 0, 0); tick();
        tick();
        chk("t5_count", got.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) chk("t5_seq", got[i], 2 * (i + 1));
        end

        // 6A. weight load on the same edge as a valid input uses the old weight
        set_in(1, 3, 0, 1, 4);
        tick();
        set_in(1, 3, 0);
        tick();
        chk("t6_old_w", s_psum_out, 6);
        set_in(1, 3, 0);
        tick();
        chk("t6_new_w", s_psum_out, 12);
        // 6B. reset with data in flight
        n_rst = 1'b0;
        tick();
        chk("t6_rst_vld", s_psum_vld, 0);
        n_rst = 1'b1;

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            int ps;
            ps = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                             : int'($signed(16'($urandom)));
            set_in(($urandom_range(0, 9) < 7),
                   int'($signed(8'($urandom))),
                   ps,
                   ($urandom_range(0, 9) == 0),
                   int'($signed(8'($urandom))),
                   ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 19) == 0));
            n_rst = ($urandom_range(0, 49) != 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
